// File: rtl/store_buf_pkg.sv
// Shared types and constants for the posted-store buffer.
//   SB_WIDTH       : address/data width held in each buffered entry
//   MEMTYPE_BYTE/WORD : encoding of the MemType bit (1 = byte, 0 = word)
//   sb_entry_t     : one buffered store {addr, data, memtype}
package store_buf_pkg;
  localparam int   SB_WIDTH     = 32;
  localparam logic MEMTYPE_BYTE = 1'b1;
  localparam logic MEMTYPE_WORD = 1'b0;

  typedef struct packed {
    logic [SB_WIDTH-1:0] addr;
    logic [SB_WIDTH-1:0] data;
    logic                memtype;
  } sb_entry_t;
endpackage

// File: rtl/sb_overlap_check.sv
// Footprint compare of one buffered store against the current load address.
// Ports:
//   entry         : buffered store (validity is qualified by the caller)
//   ld_addr       : load byte address
//   covers_byte   : entry writes the byte at ld_addr
//   overlaps_word : entry footprint intersects [ld_addr .. ld_addr+3]
//   exact_word    : entry is a word store at exactly ld_addr
//   fwd_byte      : entry's byte that lands on ld_addr (valid with covers_byte)
// All address arithmetic wraps modulo 2^SB_WIDTH, so misaligned words that
// straddle the top of the address space compare correctly.
module sb_overlap_check
  import store_buf_pkg::*;
(
  input  sb_entry_t           entry,
  input  logic [SB_WIDTH-1:0] ld_addr,
  output logic                covers_byte,
  output logic                overlaps_word,
  output logic                exact_word,
  output logic [7:0]          fwd_byte
);
  logic [SB_WIDTH-1:0] w_d_le;  // load minus entry
  logic [SB_WIDTH-1:0] w_d_el;  // entry minus load
  logic                w_is_byte;

  assign w_d_le    = ld_addr - entry.addr;
  assign w_d_el    = entry.addr - ld_addr;
  assign w_is_byte = (entry.memtype == MEMTYPE_BYTE);

  assign covers_byte   = w_is_byte ? (w_d_le == '0) : (w_d_le < SB_WIDTH'(4));
  // Two 4-byte windows intersect iff either start lies inside the other.
  assign overlaps_word = (w_d_el < SB_WIDTH'(4)) ||
                         (!w_is_byte && (w_d_le < SB_WIDTH'(4)));
  assign exact_word    = !w_is_byte && (w_d_le == '0);

  // Little-endian lane select; byte entries only cover offset 0.
  always_comb begin
    fwd_byte = entry.data[7:0];
    case (w_d_le[1:0])
      2'd1:    fwd_byte = entry.data[15:8];
      2'd2:    fwd_byte = entry.data[23:16];
      2'd3:    fwd_byte = entry.data[31:24];
      default: fwd_byte = entry.data[7:0];
    endcase
  end
endmodule

// File: rtl/store_buffer.sv
// Posted-store FIFO between the MEM-stage load/store path and a byte-addressed
// data memory with one shared address port and combinational read.
// Stores are queued and retired only in cycles the CPU is not using the port
// (or while the CPU is stalled). Loads see pending stores via forwarding or
// are stalled until the overlapping stores have drained.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   cpu_we/cpu_re   : store / load request (both high is treated as a store)
//   cpu_memtype     : 1 = byte, 0 = word
//   cpu_addr/cpu_wd : byte address / store data (byte stores use [7:0])
//   fence           : stall and drain until the buffer is empty
//   cpu_rd          : load data (0 when no load is accepted)
//   stall           : request not accepted this cycle
//   mem_*           : memory port; mem_rd is combinational from mem_addr
//   sb_empty        : no pending stores
// Build option: STORE_BUF_FWD_EN enables store-to-load forwarding; without it
// any load touching a pending store stalls until that store has drained.
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int WIDTH = SB_WIDTH,  // must equal SB_WIDTH (entry field width)
  parameter int DEPTH = 4          // power of two, >= 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_we,
  input  logic             cpu_re,
  input  logic             cpu_memtype,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wd,
  input  logic             fence,
  output logic [WIDTH-1:0] cpu_rd,
  output logic             stall,
  output logic             mem_we,
  output logic             mem_memtype,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd,
  output logic             sb_empty
);
`ifdef STORE_BUF_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  localparam int PW = $clog2(DEPTH);

  sb_entry_t     r_q [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [PW:0]   r_count;  // extra bit separates full from empty

  logic [DEPTH-1:0]      w_cov, w_ovl, w_exact;
  logic [DEPTH-1:0][7:0] w_fb;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_chk
    sb_overlap_check u_chk (
      .entry         (r_q[gi]),
      .ld_addr       (SB_WIDTH'(cpu_addr)),
      .covers_byte   (w_cov[gi]),
      .overlaps_word (w_ovl[gi]),
      .exact_word    (w_exact[gi]),
      .fwd_byte      (w_fb[gi])
    );
  end

  // Walk oldest -> youngest so the last hit written is the youngest one.
  logic            w_byte_hit, w_word_hit, w_word_exact;
  logic [7:0]      w_byte_val;
  logic [SB_WIDTH-1:0] w_word_data;
  logic [PW-1:0]   w_sel;

  always_comb begin
    w_byte_hit   = 1'b0;
    w_byte_val   = '0;
    w_word_hit   = 1'b0;
    w_word_exact = 1'b0;
    w_word_data  = '0;
    w_sel        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_sel = r_head + PW'(k);
      if ((PW+1)'(k) < r_count) begin
        if (w_cov[w_sel]) begin
          w_byte_hit = 1'b1;
          w_byte_val = w_fb[w_sel];
        end
        if (w_ovl[w_sel]) begin
          w_word_hit   = 1'b1;
          w_word_exact = w_exact[w_sel];
          w_word_data  = r_q[w_sel].data;
        end
      end
    end
  end

  logic w_load, w_is_byte, w_conflict, w_full, w_stall, w_drain, w_push;

  assign w_load    = cpu_re && !cpu_we;
  assign w_is_byte = (cpu_memtype == MEMTYPE_BYTE);
  // With forwarding, a byte load is always satisfiable and a word load only
  // when the youngest overlapping store is a word at the same address.
  assign w_conflict = w_is_byte ? (!FWD_EN && w_byte_hit)
                                : (w_word_hit && !(FWD_EN && w_word_exact));
  assign w_full  = cpu_we && (r_count == (PW+1)'(DEPTH));
  assign w_stall = rst_n && (w_full || (w_load && w_conflict) ||
                             (fence && (r_count != '0)));
  // Port is free when the CPU is idle or its request is being held off.
  assign w_drain = rst_n && (r_count != '0) && ((!cpu_we && !cpu_re) || w_stall);
  assign w_push  = rst_n && cpu_we && !w_stall;

  assign stall       = w_stall;
  assign sb_empty    = !rst_n || (r_count == '0);
  assign mem_we      = w_drain;
  assign mem_addr    = w_drain ? WIDTH'(r_q[r_head].addr) : cpu_addr;
  assign mem_wd      = w_drain ? WIDTH'(r_q[r_head].data) : cpu_wd;
  assign mem_memtype = w_drain ? r_q[r_head].memtype      : cpu_memtype;

  always_comb begin
    cpu_rd = '0;
    if (rst_n && w_load && !w_stall) begin
      if (w_is_byte)
        cpu_rd = {{(WIDTH-8){1'b0}}, (FWD_EN && w_byte_hit) ? w_byte_val : mem_rd[7:0]};
      else
        cpu_rd = (FWD_EN && w_word_hit) ? WIDTH'(w_word_data) : mem_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_q[r_tail] <= '{addr: SB_WIDTH'(cpu_addr), data: SB_WIDTH'(cpu_wd),
                         memtype: cpu_memtype};
        r_tail      <= r_tail + PW'(1);
      end
      if (w_drain) r_head <= r_head + PW'(1);
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
